axi_lite_regbank: RTL and testbench

- Parametrised AXI4-Lite slave that maps NUM_REGS data-width registers onto the bus.
- Generalises the plain AXI-Lite signal bundle into a working endpoint with:
  - independent write and read FSMs;
  - AW/W arrival in either order;
  - byte strobes;
  - per-register read-only masking;
  - SLVERR on illegal accesses.
- Sits between the system interconnect and core-side control/status logic (CSRs for the rv32 core peripherals).

---
 rtl/axi_lite_regbank_pkg.sv | 23 ++
 rtl/axi_lite_regbank_if.sv | 37 +++
 rtl/axi_lite_regbank_decode.sv | 36 +++
 rtl/axi_lite_regbank.sv | 199 +++++++++++++++++++
 tb/tb_axi_lite_regbank.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_regbank_pkg.sv
// Shared response codes, FSM state types and the byte-strobe merge helper
// for the AXI4-Lite register bank.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;

   // Sized for the widest legal bus; callers zero-extend and truncate.
   function automatic logic [63:0] strb_merge(input logic [63:0] old_data,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  strb);
      logic [63:0] merged;
      merged = old_data;
      for (int b = 0; b < 8; b++) begin
         if (strb[b]) merged[b*8 +: 8] = wdata[b*8 +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/axi_lite_regbank_if.sv
// AXI4-Lite signal bundle with master and slave views.
interface axi_lite_if #(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 6
);
   logic [AXI_ADDR_WIDTH-1:0]   AWADDR;
   logic [2:0]                  AWPROT;
   logic                        AWVALID;
   logic                        AWREADY;
   logic [AXI_DATA_WIDTH-1:0]   WDATA;
   logic [AXI_DATA_WIDTH/8-1:0] WSTRB;
   logic                        WVALID;
   logic                        WREADY;
   logic [1:0]                  BRESP;
   logic                        BVALID;
   logic                        BREADY;
   logic [AXI_ADDR_WIDTH-1:0]   ARADDR;
   logic [2:0]                  ARPROT;
   logic                        ARVALID;
   logic                        ARREADY;
   logic [AXI_DATA_WIDTH-1:0]   RDATA;
   logic [1:0]                  RRESP;
   logic                        RVALID;
   logic                        RREADY;

   modport master (
      output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARPROT, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARPROT, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
endinterface

// File: rtl/axi_lite_regbank_decode.sv
// Combinational address decoder: register index plus range and writability
// checks. One instance serves the AW path, another the AR path.
module axi_lite_regbank_decode #(
   parameter int                  AXI_DATA_WIDTH = 32,
   parameter int                  AXI_ADDR_WIDTH = 6,
   parameter int                  NUM_REGS       = 8,
   parameter logic [NUM_REGS-1:0] RO_MASK        = '0,
   localparam int                 ADDR_LSB       = $clog2(AXI_DATA_WIDTH/8),
   localparam int                 IDX_W          = AXI_ADDR_WIDTH - ADDR_LSB
) (
   input  logic [AXI_ADDR_WIDTH-1:0] addr,
   output logic [IDX_W-1:0]          idx,
   output logic                      in_range,
   output logic                      writable
);

   // Read-only mask padded to the full index space so any index is safe.
   logic [(1<<IDX_W)-1:0] ro_ext;
   logic                  unused_lsb;

   generate
      for (genvar gi = 0; gi < (1 << IDX_W); gi++) begin : g_ro
         if (gi < NUM_REGS) begin : g_real
            assign ro_ext[gi] = RO_MASK[gi];
         end else begin : g_pad
            assign ro_ext[gi] = 1'b0;
         end
      end
   endgenerate

   assign idx        = addr[AXI_ADDR_WIDTH-1:ADDR_LSB];
   assign unused_lsb = ^addr[ADDR_LSB-1:0];
   assign in_range   = (32'(idx) < 32'(NUM_REGS));
   assign writable   = in_range & ~ro_ext[idx];

endmodule

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave exposing NUM_REGS registers with byte strobes, read-only
// status registers, SLVERR on illegal accesses and per-register write pulses.
module axi_lite_regbank
   import axi_lite_pkg::*;
#(
   parameter int                  AXI_DATA_WIDTH = 32,
   parameter int                  AXI_ADDR_WIDTH = 6,
   parameter int                  NUM_REGS       = 8,
   parameter logic [NUM_REGS-1:0] RO_MASK        = '0
) (
   input  logic                               clk,
   input  logic                               reset_n,
   axi_lite_if.slave                          bus,
   output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_out,
   input  logic [NUM_REGS*AXI_DATA_WIDTH-1:0] hw_in,
   output logic [NUM_REGS-1:0]                wr_pulse
);

   localparam int ADDR_LSB = $clog2(AXI_DATA_WIDTH/8);
   localparam int IDX_W    = AXI_ADDR_WIDTH - ADDR_LSB;
   localparam int STRB_W   = AXI_DATA_WIDTH / 8;

   wr_state_t wr_state_reg, wr_state_next;
   rd_state_t rd_state_reg, rd_state_next;

   logic [IDX_W-1:0] aw_dec_idx, ar_dec_idx, aw_idx_reg, cur_idx;
   logic aw_dec_ok, ar_dec_range, aw_range_unused, ar_writable_unused;
   logic aw_held_reg, w_held_reg, aw_ok_reg, cur_ok;
   logic aw_ready, w_ready, ar_ready, aw_hs, w_hs, ar_hs, commit;
   logic [AXI_DATA_WIDTH-1:0] wdata_reg, cur_data, rd_word, rdata_reg;
   logic [STRB_W-1:0]         wstrb_reg, cur_strb;
   logic [1:0]                bresp_reg, rresp_reg;
   logic                      bvalid_reg, rvalid_reg;
   logic [AXI_DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [AXI_DATA_WIDTH-1:0] rd_src [NUM_REGS];
   logic                      unused_prot;

   assign unused_prot = ^{bus.AWPROT, bus.ARPROT};

   axi_lite_regbank_decode #(
      .AXI_DATA_WIDTH(AXI_DATA_WIDTH), .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
      .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK)
   ) u_aw_decode (
      .addr(bus.AWADDR), .idx(aw_dec_idx), .in_range(aw_range_unused), .writable(aw_dec_ok)
   );

   axi_lite_regbank_decode #(
      .AXI_DATA_WIDTH(AXI_DATA_WIDTH), .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
      .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK)
   ) u_ar_decode (
      .addr(bus.ARADDR), .idx(ar_dec_idx), .in_range(ar_dec_range), .writable(ar_writable_unused)
   );

   // Commit uses held values where a channel arrived earlier, live ones otherwise.
   assign aw_hs    = bus.AWVALID & aw_ready;
   assign w_hs     = bus.WVALID & w_ready;
   assign cur_idx  = aw_held_reg ? aw_idx_reg : aw_dec_idx;
   assign cur_ok   = aw_held_reg ? aw_ok_reg  : aw_dec_ok;
   assign cur_data = w_held_reg  ? wdata_reg  : bus.WDATA;
   assign cur_strb = w_held_reg  ? wstrb_reg  : bus.WSTRB;

   always_comb begin
      wr_state_next = wr_state_reg;
      aw_ready      = 1'b0;
      w_ready       = 1'b0;
      commit        = 1'b0;
      case (wr_state_reg)
         W_IDLE: begin
            aw_ready = ~aw_held_reg;
            w_ready  = ~w_held_reg;
            if ((aw_held_reg | bus.AWVALID) & (w_held_reg | bus.WVALID)) begin
               commit        = 1'b1;
               wr_state_next = W_RESP;
            end
         end
         W_RESP: if (bus.BREADY) wr_state_next = W_IDLE;
         default: wr_state_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) wr_state_reg <= W_IDLE;
      else          wr_state_reg <= wr_state_next;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         aw_held_reg <= 1'b0;
         w_held_reg  <= 1'b0;
         aw_idx_reg  <= '0;
         aw_ok_reg   <= 1'b0;
         wdata_reg   <= '0;
         wstrb_reg   <= '0;
         bvalid_reg  <= 1'b0;
         bresp_reg   <= RESP_OKAY;
      end else begin
         if (aw_hs) begin
            aw_held_reg <= 1'b1;
            aw_idx_reg  <= aw_dec_idx;
            aw_ok_reg   <= aw_dec_ok;
         end
         if (w_hs) begin
            w_held_reg <= 1'b1;
            wdata_reg  <= bus.WDATA;
            wstrb_reg  <= bus.WSTRB;
         end
         if (commit) begin
            bvalid_reg <= 1'b1;
            bresp_reg  <= cur_ok ? RESP_OKAY : RESP_SLVERR;
         end else if (wr_state_reg == W_RESP && bus.BREADY) begin
            bvalid_reg  <= 1'b0;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         logic                      hit;
         logic                      pulse_reg;
         logic [AXI_DATA_WIDTH-1:0] data_reg;

         assign hit = commit & cur_ok & (cur_idx == IDX_W'(gi));

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               data_reg  <= '0;
               pulse_reg <= 1'b0;
            end else begin
               pulse_reg <= hit;
               if (hit) data_reg <= AXI_DATA_WIDTH'(strb_merge(64'(data_reg), 64'(cur_data), 8'(cur_strb)));
            end
         end

         assign regs[gi]                             = data_reg;
         assign wr_pulse[gi]                         = pulse_reg;
         assign reg_out[gi*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = data_reg;

         if (RO_MASK[gi]) begin : g_ro
            assign rd_src[gi] = hw_in[gi*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
         end else begin : g_rw
            assign rd_src[gi] = regs[gi];
         end
      end
   endgenerate

   always_comb begin
      rd_state_next = rd_state_reg;
      ar_ready      = 1'b0;
      case (rd_state_reg)
         R_IDLE: begin
            ar_ready = 1'b1;
            if (bus.ARVALID) rd_state_next = R_DATA;
         end
         R_DATA: if (bus.RREADY) rd_state_next = R_IDLE;
         default: rd_state_next = R_IDLE;
      endcase
   end

   // Out-of-range indices match no entry and fall through to zero.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (ar_dec_idx == IDX_W'(i)) rd_word = rd_src[i];
      end
   end

   assign ar_hs = bus.ARVALID & ar_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rd_state_reg <= R_IDLE;
      else          rd_state_reg <= rd_state_next;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rvalid_reg <= 1'b0;
         rdata_reg  <= '0;
         rresp_reg  <= RESP_OKAY;
      end else if (ar_hs) begin
         rvalid_reg <= 1'b1;
         rdata_reg  <= ar_dec_range ? rd_word : '0;
         rresp_reg  <= ar_dec_range ? RESP_OKAY : RESP_SLVERR;
      end else if (rd_state_reg == R_DATA && bus.RREADY) begin
         rvalid_reg <= 1'b0;
      end
   end

   assign bus.AWREADY = aw_ready;
   assign bus.WREADY  = w_ready;
   assign bus.BVALID  = bvalid_reg;
   assign bus.BRESP   = bresp_reg;
   assign bus.ARREADY = ar_ready;
   assign bus.RVALID  = rvalid_reg;
   assign bus.RDATA   = rdata_reg;
   assign bus.RRESP   = rresp_reg;

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Scoreboard bench for axi_lite_regbank: expected responses are queued as
// transactions are issued and retired when the B/R handshakes complete.
module tb_axi_lite_regbank;

   localparam int             DW = 32;
   localparam int             AW = 6;
   localparam int             NR = 8;
   localparam logic [NR-1:0]  RO = 8'h01;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [1:0]    resp;
   } rd_exp_t;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [NR*DW-1:0]  reg_out;
   logic [NR*DW-1:0]  hw_in;
   logic [NR-1:0]     wr_pulse;

   logic [1:0]    exp_b [$];
   rd_exp_t       exp_r [$];
   logic [DW-1:0] model [NR];
   int            n_cmp = 0;
   int            n_mis = 0;

   axi_lite_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) bus ();

   axi_lite_regbank #(
      .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .NUM_REGS(NR), .RO_MASK(RO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus),
      .reg_out(reg_out), .hw_in(hw_in), .wr_pulse(wr_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] d,
                                           input logic [3:0] s);
      logic [DW-1:0] r;
      for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? d[b*8 +: 8] : o[b*8 +: 8];
      return r;
   endfunction

   // Retire responses as the handshakes happen.
   always @(negedge clk) begin
      if (reset_n && bus.BVALID && bus.BREADY) begin
         if (exp_b.size() == 0) check("b_unexpected", 1, 0);
         else check("bresp", bus.BRESP, exp_b.pop_front());
      end
      if (reset_n && bus.RVALID && bus.RREADY) begin
         if (exp_r.size() == 0) check("r_unexpected", 1, 0);
         else begin
            rd_exp_t e;
            e = exp_r.pop_front();
            check("rdata", bus.RDATA, e.data);
            check("rresp", bus.RRESP, e.resp);
         end
      end
   end

   // w_lead > 0: W presented that many cycles before AW; < 0: AW leads.
   task automatic write_txn(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [3:0] strb, input int w_lead);
      int idx, c, w_start, aw_start;
      logic ok;
      logic [1:0] er;
      logic [NR-1:0] ep;
      bit aw_done, w_done, aw_now, w_now;
      idx = int'(addr) >> 2;
      ok = 1'b0;
      if (idx < NR) ok = !RO[idx];
      er = ok ? 2'b00 : 2'b10;
      ep = ok ? (NR'(1) << idx) : '0;
      if (ok) model[idx] = merge(model[idx], data, strb);
      exp_b.push_back(er);
      $display("WR addr=0x%02h data=0x%08h strb=%h lead=%0d exp_resp=%0d", addr, data, strb, w_lead, er);
      w_start  = (w_lead < 0) ? -w_lead : 0;
      aw_start = (w_lead > 0) ? w_lead : 0;
      c = 0; aw_done = 0; w_done = 0;
      while (!(aw_done && w_done) && c < 40) begin
         if (c == aw_start) begin bus.AWADDR = addr; bus.AWVALID = 1'b1; end
         if (c == w_start)  begin bus.WDATA = data; bus.WSTRB = strb; bus.WVALID = 1'b1; end
         @(negedge clk);
         aw_now = bus.AWVALID && bus.AWREADY;
         w_now  = bus.WVALID && bus.WREADY;
         if (w_done && !aw_done) check("wready_wait", bus.WREADY, 0);
         if (aw_done && !w_done) check("awready_wait", bus.AWREADY, 0);
         @(posedge clk); #1;
         if (aw_now) begin bus.AWVALID = 1'b0; aw_done = 1; end
         if (w_now)  begin bus.WVALID = 1'b0; w_done = 1; end
         c++;
      end
      check("wr_handshake", aw_done && w_done, 1);
      check("bvalid_lat", bus.BVALID, 1);
      check("wr_pulse", wr_pulse, ep);
      @(posedge clk); #1;
      check("wr_pulse_clr", wr_pulse, 0);
   endtask

   task automatic read_txn(input logic [AW-1:0] addr);
      int idx, c;
      rd_exp_t e;
      bit done, now;
      idx = int'(addr) >> 2;
      if (idx < NR) begin
         e.data = RO[idx] ? hw_in[idx*DW +: DW] : model[idx];
         e.resp = 2'b00;
      end else begin
         e.data = '0;
         e.resp = 2'b10;
      end
      exp_r.push_back(e);
      $display("RD addr=0x%02h exp_data=0x%08h exp_resp=%0d", addr, e.data, e.resp);
      bus.ARADDR = addr; bus.ARVALID = 1'b1;
      c = 0; done = 0;
      while (!done && c < 40) begin
         @(negedge clk);
         now = bus.ARVALID && bus.ARREADY;
         @(posedge clk); #1;
         if (now) begin bus.ARVALID = 1'b0; done = 1; end
         c++;
      end
      check("rd_handshake", done, 1);
      check("rvalid_lat", bus.RVALID, 1);
      @(posedge clk); #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_awready"}, bus.AWREADY, 1);
      check({tag, "_wready"},  bus.WREADY, 1);
      check({tag, "_arready"}, bus.ARREADY, 1);
      check({tag, "_bvalid"},  bus.BVALID, 0);
      check({tag, "_rvalid"},  bus.RVALID, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [AW-1:0] ra;
      int            lead;
      for (int i = 0; i < NR; i++) model[i] = '0;
      for (int i = 0; i < NR; i++) hw_in[i*DW +: DW] = 32'hA5A5_0000 | 32'(i);
      hw_in[0 +: DW] = 32'hCAFE_F00D;
      bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 0;
      bus.WDATA = '0;  bus.WSTRB = '0;  bus.WVALID = 0;
      bus.BREADY = 1;
      bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 0;
      bus.RREADY = 1;

      repeat (3) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      check_idle("reset");
      check("reset_regs", reg_out, '0);
      check("reset_pulse", wr_pulse, 0);
      check("reset_rdata", bus.RDATA, 0);
      check("reset_bresp", bus.BRESP, 0);
      check("reset_rresp", bus.RRESP, 0);

      // Same-cycle AW/W
      write_txn(6'h04, 32'hDEAD_BEEF, 4'hF, 0);
      check("reg1", reg_out[1*DW +: DW], 32'hDEAD_BEEF);
      read_txn(6'h04);

      // W leads AW by three cycles, partial strobes
      write_txn(6'h08, 32'hFFFF_FFFF, 4'hF, 0);
      write_txn(6'h08, 32'h1234_5678, 4'b0101, 3);
      check("reg2_strb", reg_out[2*DW +: DW], 32'hFF34_FF78);
      read_txn(6'h08);

      // Read-only register
      write_txn(6'h00, 32'h1111_1111, 4'hF, 0);
      check("reg0_ro", reg_out[0 +: DW], 0);
      read_txn(6'h00);

      // Out-of-range index
      write_txn(6'h3C, 32'h2222_2222, 4'hF, 0);
      read_txn(6'h3C);

      // Backpressure on both response channels
      bus.BREADY = 0; bus.RREADY = 0;
      write_txn(6'h0C, 32'h55AA_55AA, 4'hF, 0);
      read_txn(6'h04);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_bvalid", bus.BVALID, 1);
         check("bp_bresp", bus.BRESP, 0);
         check("bp_rvalid", bus.RVALID, 1);
         check("bp_rdata", bus.RDATA, model[1]);
         check("bp_rresp", bus.RRESP, 0);
         check("bp_awready", bus.AWREADY, 0);
         check("bp_wready", bus.WREADY, 0);
         check("bp_arready", bus.ARREADY, 0);
      end
      check("reg3", reg_out[3*DW +: DW], 32'h55AA_55AA);
      @(posedge clk); #1;
      bus.BREADY = 1; bus.RREADY = 1;
      @(posedge clk); #1;
      check_idle("bp_release");

      // Mixed orderings, random data/strobes, ignored low address bits
      for (int k = 0; k < 6; k++) begin
         ra   = AW'(($urandom_range(1, NR-1) << 2) | $urandom_range(0, 3));
         lead = int'($urandom_range(0, 4)) - 2;
         write_txn(ra, $urandom, 4'($urandom), lead);
         read_txn(ra);
      end

      // Reset while a write response is pending
      bus.BREADY = 0;
      write_txn(6'h10, 32'h1111_2222, 4'hF, -2);
      check("rst_pre_bvalid", bus.BVALID, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check_idle("async_rst");
      check("async_rst_regs", reg_out, '0);
      check("async_rst_pulse", wr_pulse, 0);
      exp_b.delete();
      exp_r.delete();
      for (int i = 0; i < NR; i++) model[i] = '0;
      @(negedge clk) reset_n = 1'b1;
      bus.BREADY = 1;
      @(posedge clk); #1;
      read_txn(6'h10);
      read_txn(6'h04);

      repeat (2) @(posedge clk);
      #1;
      check("b_queue_empty", exp_b.size(), 0);
      check("r_queue_empty", exp_r.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
